// File: rtl/borrow_select_subtractor_seq.sv
// borrow_select_subtractor_seq
//   Multi-cycle WIDTH-bit subtractor: diff = a - b - borrow_in (mod 2^WIDTH).
//   Each cycle handles one CHUNK-bit slice. Both borrow-in cases are computed
//   in parallel, and the registered running borrow picks one of them.
//   Optional macro BORROW_SELECT_OVF_EN adds a signed-overflow output (ovf).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (a, b, borrow_in)
//   out_valid/out_ready result handshake (diff, borrow_out[, ovf])
module borrow_select_subtractor_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef BORROW_SELECT_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef BORROW_SELECT_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0]   a_c, b_c;
    logic [CHUNK:0]     d0, d1;
    logic [CHUNK-1:0]   sel_diff;
    logic               sel_borrow;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            idx_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
`ifdef BORROW_SELECT_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            borrow_q     <= borrow_d;
            idx_q        <= idx_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
`ifdef BORROW_SELECT_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    // Chunk datapath: both borrow cases, then select by running borrow
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_c = a_q[i*CHUNK +: CHUNK];
                b_c = b_q[i*CHUNK +: CHUNK];
            end
        end
        // The extra top bit of each (CHUNK+1)-bit difference is the borrow.
        d0         = {1'b0, a_c} - {1'b0, b_c};
        d1         = d0 - (CHUNK+1)'(1);
        sel_diff   = borrow_q ? d1[CHUNK-1:0] : d0[CHUNK-1:0];
        sel_borrow = borrow_q ? d1[CHUNK]     : d0[CHUNK];
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        borrow_d     = borrow_q;
        idx_d        = idx_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
`ifdef BORROW_SELECT_OVF_EN
        ovf_d        = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    borrow_d   = borrow_in;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < int'(N); i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[i*CHUNK +: CHUNK] = sel_diff;
                    end
                end
                borrow_d = sel_borrow;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d        = '0;
                    borrow_out_d = sel_borrow;
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
`ifdef BORROW_SELECT_OVF_EN
                    // Signed overflow: operands differ in sign and result sign differs from a
                    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef BORROW_SELECT_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Testbench for borrow_select_subtractor_seq (WIDTH=16, CHUNK=4).
module tb_borrow_select_subtractor_seq;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef BORROW_SELECT_OVF_EN
    logic             ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    borrow_select_subtractor_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef BORROW_SELECT_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] exp_diff;
        logic        exp_bout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [15:0] ed, input logic eb, input logic eo);
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " borrow_out"}, 32'(borrow_out), 32'(eb));
`ifdef BORROW_SELECT_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
    endtask

    // Full op: accept, measure latency, check result, complete handshake
    task automatic run_op(input string tag, input vec_t v);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; borrow_in = v.bin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, " latency"}, 32'(cnt), 32'd4);
        check_result(tag, v.exp_diff, v.exp_bout, v.exp_ovf);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] held_diff;
        logic        held_bout;
        vec_t        v;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; borrow_in = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow_out", 32'(borrow_out), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure with rejected in_valid pulses during RUN and DONE
        a = 16'h1234; b = 16'h0234; borrow_in = 1'b0; in_valid = 1'b1;
        step();
        a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b1;
        step();
        check("bp in_ready in RUN", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step(); step(); step();
        check("bp out_valid at latency", 32'(out_valid), 32'd1);
        check_result("bp", 16'h1000, 1'b0, 1'b0);
        held_diff = diff;
        held_bout = borrow_out;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            step();
            check("bp out_valid held", 32'(out_valid), 32'd1);
            check("bp diff held", 32'(diff), 32'(held_diff));
            check("bp borrow_out held", 32'(borrow_out), 32'(held_bout));
            check("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp out_valid cleared", 32'(out_valid), 32'd0);
        check("bp in_ready restored", 32'(in_ready), 32'd1);
        step();
        check("bp no stray accept", 32'(in_ready), 32'd1);
        check("bp no stray result", 32'(out_valid), 32'd0);

        // Reset at RUN idx=2
        a = 16'h1234; b = 16'h0234; borrow_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst mid in_ready", 32'(in_ready), 32'd1);
        check("rst mid out_valid", 32'(out_valid), 32'd0);
        check("rst mid diff", 32'(diff), 32'd0);
        check("rst mid borrow_out", 32'(borrow_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst mid no late result", 32'(out_valid), 32'd0);
        end
        v = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        run_op("after rst", v);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        a = 16'h1000; b = 16'h0001; borrow_in = 1'b0; in_valid = 1'b1;
        step();                                 // edge 0
        in_valid = 1'b0;
        step(); step(); step();                 // edges 1..3
        check("b2b out_valid edge3", 32'(out_valid), 32'd0);
        step();                                 // edge 4
        check("b2b out_valid edge4", 32'(out_valid), 32'd1);
        check_result("b2b first", 16'h0FFF, 1'b0, 1'b0);
        step();                                 // edge 5
        check("b2b out_valid edge5", 32'(out_valid), 32'd0);
        check("b2b in_ready edge5", 32'(in_ready), 32'd1);
        a = 16'h7FFF; b = 16'hFFFF; borrow_in = 1'b0; in_valid = 1'b1;
        step();                                 // edge 6
        in_valid = 1'b0;
        check("b2b in_ready edge6", 32'(in_ready), 32'd0);
        step(); step(); step(); step();         // edges 7..10
        check("b2b out_valid edge10", 32'(out_valid), 32'd1);
        check_result("b2b second", 16'h8000, 1'b1, 1'b1);
        step();
        out_ready = 1'b0;
        check("b2b final in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/borrow_select_subtractor_seq.md
Name: borrow_select_subtractor_seq

Overview:
- Multi-cycle WIDTH-bit subtractor: computes diff = a - b - borrow_in.
- Works CHUNK bits per clock. For each chunk, both borrow-in cases (0 and 1) are computed in parallel, then the registered running borrow selects one.
- Valid/ready handshake on input and output. Sits in the arithmetic datapath as the subtract counterpart to the team's carry-select adder.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per clock cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- borrow_in  input  1  initial borrow
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
- borrow_out  output  1  1 when a < b + borrow_in (unsigned)

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0, chunk index=0.
- rst overrides everything, including mid-RUN and in DONE: the operation in flight is discarded and no out_valid is produced for it.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, borrow_in; running borrow <= borrow_in; idx <= 0; go to RUN.
- State RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, for chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK):
    - d0 = a_c - b_c, with borrow b0;
    - d1 = a_c - b_c - 1, with borrow b1;
    - if running borrow=1, select (d1,b1), else (d0,b0).
  - Write the selected result into diff chunk idx; update running borrow; idx <= idx+1.
  - After chunk N-1 is written: borrow_out <= final borrow, out_valid <= 1, go to DONE.
- Latency: out_valid is first seen high exactly N cycles after the accepting edge (N=4 for defaults).
- State DONE:
  - in_ready=0; out_valid=1.
  - diff and borrow_out are held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - No accept in the same cycle. Minimum issue interval: N+2 cycles.
- diff and borrow_out are undefined-but-stable while out_valid=0. Bench checks them only when out_valid=1.
- Wrap-around: results are modulo 2^WIDTH; borrow_out reports the underflow.
- Index boundary: when N=1, RUN lasts one cycle.

Optional Feature:
- Macro: BORROW_SELECT_OVF_EN
- Defined:
  - Adds output port ovf (1 bit).
  - ovf = two's-complement signed overflow of a - b - borrow_in, i.e. (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Registered together with borrow_out: reset 0, valid and held under the same rules as diff.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic (WIDTH=16, CHUNK=4): a=0x1234, b=0x0234, borrow_in=0 -> diff=0x1000, borrow_out=0; out_valid rises 4 cycles after accept; ovf=0.
- Borrow ripple across all chunks: a=0x1000, b=0x0001 -> diff=0x0FFF, borrow_out=0. Then a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1.
- Borrow-in and signed overflow: a=0x8000, b=0x0000, borrow_in=1 -> diff=0x7FFF, borrow_out=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow_out=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid rises: diff, borrow_out and out_valid stay stable; in_ready=0.
  - A new in_valid pulse during RUN/DONE is not accepted.
  - Then out_ready=1 for one cycle: out_valid=0 next cycle, in_ready=1.
- Reset mid-operation: assert rst for 1 cycle at RUN idx=2 -> next cycle in_ready=1, out_valid=0, diff=0, borrow_out=0. A fresh op a=0x0005, b=0x0003 then gives diff=0x0002.
- Back-to-back ops with out_ready tied 1: accept at edge 0, out_valid high after edge 4, handshake completes at edge 5, in_ready=1 after edge 5, next accept at edge 6, second result correct.
